alu_vec_runner: RTL and testbench
=================================

// Module: alu_vec_runner
// PURPOSE
//  Self-sequencing ALU exerciser for board bring-up. Holds an NVEC-entry operand store
//  (reset-loaded with corner-case patterns, host-writable while idle), runs each vector
//  through a WIDTH-bit ALU for one op or a sweep of all 8 ops, and accumulates a result
//  signature. Displays result/signature/flag bytes on an 8-bit LED bank.
// PARAMETERS
//  WIDTH  32  operand/result width; multiple of 8, range 8..64
//  NVEC   8   operand-store depth; range 2..16
// PORTS
//  clk        in   1              single clock, all state on rising edge
//  rst_n      in   1              synchronous, active-low reset
//  start      in   1              1-cycle pulse; begins a run (sampled in IDLE/DONE only)
//  op_sweep   in   1              1: each vector runs ops 0..7; 0: runs alu_op only
//  alu_op     in   3              op for non-sweep runs, latched at start
//  step_mode  in   1              1: pause after every result until step
//  step       in   1              1-cycle pulse; releases HOLD
//  vec_we     in   1              operand-store write strobe
//  vec_addr   in   $clog2(NVEC)    write index
//  vec_a      in   WIDTH          operand A write data
//  vec_b      in   WIDTH          operand B write data
//  disp_sel   in   5              LED source select (see BEHAVIOUR)
//  led        out  8              display byte (registered)
//  busy       out  1              high in LOAD/EXEC/ACC/HOLD
//  done       out  1              high in DONE
//  res_valid  out  1              1-cycle pulse per result, in ACC
// BEHAVIOUR
//  Reset: state IDLE; led, busy, done, res_valid, F_r, ZF_r, OF_r, sig all 0; store reloaded.
//  Default store (truncated to WIDTH): 0:(0,0) 1:(3,0x607) 2:(MIN,MIN) 3:(MAX,MAX) 4:(-1,-1)
//   5:(MIN,-1) 6:(-1,MIN) 7:(rep 0x12345678, rep 0x33332222); entries >=8 are (0,0);
//   MIN/MAX are signed extremes. If NVEC<8, only the first NVEC entries are used.
//  Ops: 0 AND,1 OR,2 XOR,3 NOR,4 ADD,5 SUB(A-B),6 SLT signed(0/1),7 SLL B<<A[log2W-1:0].
//   ZF=(F==0). OF=signed overflow for ADD/SUB, else 0. F wraps modulo 2^WIDTH.
//  FSM: IDLE -start-> LOAD (vec_idx=0, op_idx=op_sweep?0:alu_op, sig=0)
//   LOAD: A_r,B_r <= store[vec_idx] (1 cycle) -> EXEC
//   EXEC: F_r,ZF_r,OF_r <= alu(op_idx,A_r,B_r) (1 cycle) -> ACC
//   ACC: sig <= rotl(sig,1) ^ F_r ^ {ZF_r,OF_r} (2 LSBs); res_valid=1;
//        -> HOLD if step_mode, else ADVANCE decision
//   HOLD: wait for step, then ADVANCE decision; step outside HOLD ignored.
//   ADVANCE: if op_sweep && op_idx!=7: op_idx++ -> EXEC (operands reused);
//        else if vec_idx!=NVEC-1: vec_idx++, op_idx reset -> LOAD; else -> DONE.
//   DONE: held; start -> LOAD with sig cleared (new run).
//  Auto-mode latency: single-op result every 3 cycles; sweep: 3 cycles first op of a vector,
//   2 per subsequent op. Non-sweep run: start at cycle 0 -> done high at cycle 3*NVEC+1.
//  Store writes: accepted only when busy=0; ignored while busy. Write and start in same
//   cycle: write commits first; the run sees new data.
//  start while busy: ignored. Reset mid-run: returns to IDLE on that edge, run lost.
//  Display (led registered, 1-cycle lag from disp_sel): [4]=0 -> F_r byte [2:0];
//   [4:3]=10 -> sig byte [2:0]; [4:3]=11 -> {ZF_r,5'b0,OF_r,done}.
//   Byte index >= WIDTH/8 -> 8'h00.
// STRUCTURE
//  alu_pkg: op-code localparams, FSM state enum, default-vector function (WIDTH, index).
//  Sub-module alu_core: combinational, parametrised WIDTH, (op,A,B) -> (F,ZF,OF).
//  Top holds operand store, FSM, counters, signature, LED mux.
// TESTING (WIDTH=32, NVEC=8)
//  op=ADD, vec1 via step_mode -> F=0x0000060A; disp_sel 0/1 -> led 0x0A/0x06; ZF=0, OF=0.
//  op=ADD, vec3 -> F=0xFFFFFFFE, OF=1; vec6 -> F=0x7FFFFFFF, OF=1.
//  op=SUB, vec2 -> F=0, ZF=1, OF=0; vec5 -> F=0x80000001, OF=0.
//  Auto non-sweep run: done rises 25 cycles after start; exactly 8 res_valid pulses;
//   sig matches model; sweep run gives 64 pulses.
//  Write vec_addr=0 (5,7) idle, op=SLT -> F=1; write attempted while busy -> store unchanged.
//  rst_n low mid-sweep -> next cycle busy=0, done=0, led=0, vec0 restored to (0,0).

Source files
------------

// File: rtl/alu_vec_runner_pkg.sv
// Shared definitions for the ALU vector runner: op codes, FSM states and
// the reset contents of the operand store.
package alu_vec_runner_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_SLL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_ACC,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Corner-case operand pair for store entry idx, masked to width bits.
    // sel_b picks operand B, otherwise operand A.
    function automatic logic [63:0] default_vec(input int width, input int idx, input bit sel_b);
        logic [63:0] mask;
        logic [63:0] min_v;
        logic [63:0] max_v;
        logic [63:0] a;
        logic [63:0] b;
        mask  = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        min_v = 64'd1 << (width - 1);
        max_v = min_v - 64'd1;
        case (idx)
            1:       begin a = 64'd3;                 b = 64'h607;                 end
            2:       begin a = min_v;                 b = min_v;                   end
            3:       begin a = max_v;                 b = max_v;                   end
            4:       begin a = mask;                  b = mask;                    end
            5:       begin a = min_v;                 b = mask;                    end
            6:       begin a = mask;                  b = min_v;                   end
            7:       begin a = 64'h1234_5678_1234_5678; b = 64'h3333_2222_3333_2222; end
            default: begin a = 64'd0;                 b = 64'd0;                   end
        endcase
        return (sel_b ? b : a) & mask;
    endfunction

endpackage

// File: rtl/alu_vec_runner_if.sv
// Host-side control, store-write and display signals of the ALU vector runner.
interface alu_vec_runner_if #(
    parameter int WIDTH = 32,
    parameter int NVEC  = 8
);
    localparam int AW = $clog2(NVEC);

    logic             start;
    logic             op_sweep;
    logic [2:0]       alu_op;
    logic             step_mode;
    logic             step;
    logic             vec_we;
    logic [AW-1:0]    vec_addr;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic [4:0]       disp_sel;
    logic [7:0]       led;
    logic             busy;
    logic             done;
    logic             res_valid;

    modport master (
        output start, op_sweep, alu_op, step_mode, step,
        output vec_we, vec_addr, vec_a, vec_b, disp_sel,
        input  led, busy, done, res_valid
    );

    modport slave (
        input  start, op_sweep, alu_op, step_mode, step,
        input  vec_we, vec_addr, vec_a, vec_b, disp_sel,
        output led, busy, done, res_valid
    );

endinterface

// File: rtl/alu_vec_runner_core.sv
// Combinational WIDTH-bit ALU: eight ops, zero flag and signed overflow.
module alu_core
    import alu_vec_runner_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic             zf,
    output logic             of
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Result select; overflow only meaningful for add/subtract.
    always_comb begin
        f  = '0;
        of = 1'b0;
        case (op)
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_XOR: f = a ^ b;
            OP_NOR: f = ~(a | b);
            OP_ADD: begin
                f  = sum;
                of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                f  = diff;
                of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: f = b << a[SW-1:0];
        endcase
        zf = (f == '0);
    end

endmodule

// File: rtl/alu_vec_runner.sv
// ALU vector runner: operand store, run sequencer, signature and LED display.
//
// state | meaning
// IDLE  | waiting for start, store writable
// LOAD  | fetch operand pair of current vector
// EXEC  | register ALU result and flags
// ACC   | fold result into signature, res_valid pulse
// HOLD  | step mode pause until step
// DONE  | run finished, store writable, start re-runs
module alu_vec_runner
    import alu_vec_runner_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NVEC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_vec_runner_if.slave  bus
);

    localparam int AW = $clog2(NVEC);
    localparam int NB = WIDTH / 8;
    localparam logic [AW-1:0] LAST_VEC = AW'(NVEC - 1);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] store_a [NVEC];
    logic [WIDTH-1:0] store_b [NVEC];

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] f_r;
    logic [WIDTH-1:0] sig;
    logic             zf_r;
    logic             of_r;
    logic [AW-1:0]    vec_idx;
    logic [2:0]       op_idx;
    logic             sweep_r;

    logic [WIDTH-1:0] alu_f;
    logic             alu_zf;
    logic             alu_of;

    logic             busy_int;
    logic             done_int;
    logic             advance;
    logic             start_run;
    logic             last_op;
    logic             last_vec;
    logic [7:0]       led_r;
    logic [7:0]       led_nxt;

    assign busy_int = (state == ST_LOAD) || (state == ST_EXEC) ||
                      (state == ST_ACC)  || (state == ST_HOLD);
    assign done_int = (state == ST_DONE);
    assign last_op  = !sweep_r || (op_idx == 3'd7);
    assign last_vec = (vec_idx == LAST_VEC);

    assign bus.busy      = busy_int;
    assign bus.done      = done_int;
    assign bus.res_valid = (state == ST_ACC);
    assign bus.led       = led_r;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op (op_idx),
        .a  (a_r),
        .b  (b_r),
        .f  (alu_f),
        .zf (alu_zf),
        .of (alu_of)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; advance covers the post-result decision from ACC or HOLD.
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        start_run = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    start_run = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_ACC;
            ST_ACC: begin
                if (bus.step_mode) state_nxt = ST_HOLD;
                else               advance   = 1'b1;
            end
            ST_HOLD: advance = bus.step;
            default: state_nxt = ST_IDLE;
        endcase
        if (advance) begin
            if (!last_op)       state_nxt = ST_EXEC;
            else if (!last_vec) state_nxt = ST_LOAD;
            else                state_nxt = ST_DONE;
        end
    end

    // Operand store: reloaded with corner cases on reset, host writes only while not busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NVEC; i++) begin
                store_a[i] <= WIDTH'(default_vec(WIDTH, i, 1'b0));
                store_b[i] <= WIDTH'(default_vec(WIDTH, i, 1'b1));
            end
        end else if (bus.vec_we && !busy_int && (int'(bus.vec_addr) < NVEC)) begin
            store_a[bus.vec_addr] <= bus.vec_a;
            store_b[bus.vec_addr] <= bus.vec_b;
        end
    end

    // Run counters, operand/result registers and signature.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_idx <= '0;
            op_idx  <= '0;
            sweep_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            f_r     <= '0;
            zf_r    <= 1'b0;
            of_r    <= 1'b0;
            sig     <= '0;
        end else begin
            if (start_run) begin
                vec_idx <= '0;
                op_idx  <= bus.op_sweep ? 3'd0 : bus.alu_op;
                sweep_r <= bus.op_sweep;
                sig     <= '0;
            end
            if (state == ST_LOAD) begin
                a_r <= store_a[vec_idx];
                b_r <= store_b[vec_idx];
            end
            if (state == ST_EXEC) begin
                f_r  <= alu_f;
                zf_r <= alu_zf;
                of_r <= alu_of;
            end
            if (state == ST_ACC) begin
                sig <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ f_r ^ {{(WIDTH-2){1'b0}}, zf_r, of_r};
            end
            if (advance) begin
                if (!last_op) begin
                    op_idx <= op_idx + 3'd1;
                end else if (!last_vec) begin
                    vec_idx <= vec_idx + AW'(1);
                    if (sweep_r) op_idx <= 3'd0;
                end
            end
        end
    end

    // LED source mux; byte indices beyond the word read as zero.
    always_comb begin
        logic [7:0] f_byte;
        logic [7:0] s_byte;
        f_byte = 8'h00;
        s_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (bus.disp_sel[2:0] == 3'(i)) begin
                f_byte = f_r[8*i +: 8];
                s_byte = sig[8*i +: 8];
            end
        end
        if (!bus.disp_sel[4])      led_nxt = f_byte;
        else if (!bus.disp_sel[3]) led_nxt = s_byte;
        else                       led_nxt = {zf_r, 5'b0, of_r, done_int};
    end

    // Registered display byte.
    always_ff @(posedge clk) begin
        if (!rst_n) led_r <= 8'h00;
        else        led_r <= led_nxt;
    end

endmodule

// File: tb/tb_alu_vec_runner.sv
// Scoreboard bench for alu_vec_runner (WIDTH=32, NVEC=8).
module tb_alu_vec_runner;

    localparam int WIDTH = 32;
    localparam int NVEC  = 8;
    localparam int LIMIT = 5000;

    typedef struct {
        logic [31:0] f;
        logic        zf;
        logic        of;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_vec_runner_if #(.WIDTH(WIDTH), .NVEC(NVEC)) bus ();

    alu_vec_runner #(.WIDTH(WIDTH), .NVEC(NVEC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    res_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          pulses = 0;
    int          exp_pulses = 0;
    logic [31:0] ref_a [NVEC];
    logic [31:0] ref_b [NVEC];
    logic [31:0] exp_sig;
    logic        last_zf;
    logic        last_of;
    bit          mon_own = 1'b0;
    logic [4:0]  mon_disp = 5'd0;
    logic [4:0]  stim_disp = 5'd0;
    bit          pend_wr = 1'b0;
    logic [2:0]  pend_addr;
    logic [31:0] pend_a;
    logic [31:0] pend_b;

    assign bus.disp_sel = mon_own ? mon_disp : stim_disp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU from the op definitions, using signed integer arithmetic.
    function automatic res_t ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        longint sa;
        longint sb;
        longint wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.of = 1'b0;
        case (op)
            0: r.f = a & b;
            1: r.f = a | b;
            2: r.f = a ^ b;
            3: r.f = ~(a | b);
            4: begin
                wide = sa + sb;
                r.f  = 32'(wide);
                r.of = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            5: begin
                wide = sa - sb;
                r.f  = 32'(wide);
                r.of = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            6: r.f = (sa < sb) ? 32'd1 : 32'd0;
            default: r.f = b << a[4:0];
        endcase
        r.zf = (r.f == 32'd0);
        return r;
    endfunction

    task automatic load_defaults();
        ref_a[0] = 32'h0000_0000; ref_b[0] = 32'h0000_0000;
        ref_a[1] = 32'h0000_0003; ref_b[1] = 32'h0000_0607;
        ref_a[2] = 32'h8000_0000; ref_b[2] = 32'h8000_0000;
        ref_a[3] = 32'h7FFF_FFFF; ref_b[3] = 32'h7FFF_FFFF;
        ref_a[4] = 32'hFFFF_FFFF; ref_b[4] = 32'hFFFF_FFFF;
        ref_a[5] = 32'h8000_0000; ref_b[5] = 32'hFFFF_FFFF;
        ref_a[6] = 32'hFFFF_FFFF; ref_b[6] = 32'h8000_0000;
        ref_a[7] = 32'h1234_5678; ref_b[7] = 32'h3333_2222;
    endtask

    // Queue every expected result of a run and compute the final signature.
    task automatic plan_run(input int op, input bit sweep);
        res_t r;
        exp_sig = 32'd0;
        exp_pulses = 0;
        for (int v = 0; v < NVEC; v++) begin
            for (int k = 0; k < (sweep ? 8 : 1); k++) begin
                r = ref_alu(sweep ? k : op, ref_a[v], ref_b[v]);
                exp_q.push_back(r);
                exp_sig = {exp_sig[30:0], exp_sig[31]} ^ r.f ^ {30'd0, r.zf, r.of};
                last_zf = r.zf;
                last_of = r.of;
                exp_pulses++;
            end
        end
    endtask

    task automatic write_vec(input int addr, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.vec_we = 1'b1;
        bus.vec_addr = 3'(addr);
        bus.vec_a = a;
        bus.vec_b = b;
        @(negedge clk);
        bus.vec_we = 1'b0;
        ref_a[addr] = a;
        ref_b[addr] = b;
    endtask

    task automatic read_led(input logic [4:0] sel, output logic [7:0] val);
        @(negedge clk);
        stim_disp = sel;
        @(negedge clk);
        val = bus.led;
    endtask

    task automatic do_run(input int op, input bit sweep, input bit stepm, input bit busy_wr,
                          output int cyc);
        logic [7:0] v;
        if (pend_wr) begin
            ref_a[pend_addr] = pend_a;
            ref_b[pend_addr] = pend_b;
        end
        plan_run(op, sweep);
        pulses = 0;
        @(negedge clk);
        bus.alu_op = 3'(op);
        bus.op_sweep = sweep;
        bus.step_mode = stepm;
        bus.start = 1'b1;
        if (pend_wr) begin
            bus.vec_we = 1'b1;
            bus.vec_addr = pend_addr;
            bus.vec_a = pend_a;
            bus.vec_b = pend_b;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.vec_we = 1'b0;
        pend_wr = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < LIMIT) begin
            if (busy_wr && cyc == 4) begin
                bus.vec_we = 1'b1;
                bus.vec_addr = 3'd0;
                bus.vec_a = $urandom;
                bus.vec_b = $urandom;
            end else begin
                bus.vec_we = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.vec_we = 1'b0;
        chk("done_reached", 32'(bus.done), 32'd1);
        chk("busy_in_done", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            read_led(5'(16 + i), v);
            chk($sformatf("sig_byte%0d", i), 32'(v), 32'(exp_sig[8*i +: 8]));
        end
        read_led(5'd24, v);
        chk("flags_done", 32'(v), 32'({last_zf, 5'b0, last_of, 1'b1}));
        read_led(5'd5, v);
        chk("f_byte_out_of_range", 32'(v), 32'd0);
        chk("pulse_count", pulses, exp_pulses);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: on each result pop the expectation; in step mode inspect it in HOLD, then step.
    initial begin
        res_t       e;
        logic [7:0] exp_byte;
        bus.step = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.res_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got res_valid expected none");
                end else begin
                    e = exp_q.pop_front();
                    if (bus.step_mode) begin
                        mon_own = 1'b1;
                        for (int i = 0; i < 5; i++) begin
                            mon_disp = (i < 4) ? 5'(i) : 5'd24;
                            exp_byte = (i < 4) ? e.f[8*i +: 8] : {e.zf, 5'b0, e.of, 1'b0};
                            @(negedge clk);
                            chk($sformatf("res%0d_led_sel%0d", pulses, mon_disp),
                                32'(bus.led), 32'(exp_byte));
                        end
                        mon_own = 1'b0;
                        bus.step = 1'b1;
                        @(negedge clk);
                        bus.step = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        bus.start = 1'b0;
        bus.op_sweep = 1'b0;
        bus.alu_op = 3'd0;
        bus.step_mode = 1'b0;
        bus.vec_we = 1'b0;
        bus.vec_addr = 3'd0;
        bus.vec_a = 32'd0;
        bus.vec_b = 32'd0;
        stim_disp = 5'd24;
        load_defaults();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_res_valid", 32'(bus.res_valid), 32'd0);
        chk("reset_led", 32'(bus.led), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_run(4, 1'b0, 1'b1, 1'b0, cyc);
        do_run(5, 1'b0, 1'b1, 1'b0, cyc);

        for (int n = 0; n < 3; n++) begin
            do_run(int'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0, cyc);
            chk("auto_latency", cyc, 3 * NVEC + 1);
        end

        do_run(0, 1'b1, 1'b0, 1'b0, cyc);
        chk("sweep_latency", cyc, 8 * NVEC * 2 + NVEC + 1);

        write_vec(0, 32'd5, 32'd7);
        do_run(6, 1'b0, 1'b1, 1'b0, cyc);

        do_run(int'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b1, cyc);
        do_run(2, 1'b0, 1'b1, 1'b0, cyc);

        for (int i = 0; i < NVEC; i++) write_vec(i, $urandom, $urandom);
        ref_a[2] = 32'h0000_0000 | ($urandom & 32'h1F);
        write_vec(2, ref_a[2], ref_b[2]);
        do_run(0, 1'b1, 1'b1, 1'b0, cyc);

        pend_wr = 1'b1;
        pend_addr = 3'd3;
        pend_a = $urandom;
        pend_b = $urandom;
        do_run(4, 1'b0, 1'b0, 1'b0, cyc);

        // Reset in the middle of an automatic sweep.
        plan_run(0, 1'b1);
        stim_disp = 5'd2;
        @(negedge clk);
        bus.op_sweep = 1'b1;
        bus.step_mode = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_reset_busy", 32'(bus.busy), 32'd0);
        chk("midrun_reset_done", 32'(bus.done), 32'd0);
        chk("midrun_reset_led", 32'(bus.led), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        load_defaults();
        do_run(4, 1'b0, 1'b1, 1'b0, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
